// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Exhaustive stimulus/response checker for a small combinational block.
//   On start it walks dut_x through every input vector 0 .. 2^N_IN-1. Each
//   vector is held for SETTLE_CYCLES+2 cycles and then dut_y is sampled and
//   compared against the packed EXPECTED table. The sweep result is reported
//   as a mismatch count, a pass flag and the index of the first failing vector.
//
//   Optional build macro: TT_CHECK_CAPTURE_EN
//     When defined, every sampled dut_y is stored per vector and can be read
//     back combinationally through cap_addr / cap_data.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active high
//   start       in   launch a sweep (honoured in IDLE or DONE only)
//   dut_y       in   [N_OUT]   outputs of the block under test
//   cap_addr    in   [N_IN]    capture read address   (TT_CHECK_CAPTURE_EN)
//   cap_data    out  [N_OUT]   captured dut_y         (TT_CHECK_CAPTURE_EN)
//   dut_x       out  [N_IN]    vector driven onto the block under test
//   busy        out  sweep in progress
//   done        out  level, sweep finished, cleared by start or rst
//   pass        out  valid with done; no mismatches
//   err_count   out  [N_IN+1]  number of mismatching vectors
//   fail_valid  out  at least one mismatch seen
//   fail_idx    out  [N_IN]    first mismatching vector
module truth_table_checker #(
    parameter int N_IN          = 3,
    parameter int N_OUT         = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = 16'h5602
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_OUT-1:0]   dut_y,
`ifdef TT_CHECK_CAPTURE_EN
    input  logic [N_IN-1:0]    cap_addr,
    output logic [N_OUT-1:0]   cap_data,
`endif
    output logic [N_IN-1:0]    dut_x,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_IN:0]      err_count,
    output logic               fail_valid,
    output logic [N_IN-1:0]    fail_idx
);

    localparam int          NVEC       = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NVEC - 1);
    localparam logic [3:0]  CNT_RELOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q;
    logic [N_IN-1:0]   idx_q;
    logic [3:0]        cnt_q;
    logic [N_OUT-1:0]  exp_y;
    logic              mismatch;

    assign exp_y = EXPECTED[N_OUT*idx_q +: N_OUT];
    // Plain inequality: X/Z on dut_y is not masked; an unknown compare
    // result is simply not counted as a mismatch.
    assign mismatch = (dut_y != exp_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            dut_x      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        idx_q      <= '0;
                        dut_x      <= '0;
                        cnt_q      <= CNT_RELOAD;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_idx   <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) state_q <= SAMPLE;
                    else             cnt_q   <= cnt_q - 4'd1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_idx   <= idx_q;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        dut_x   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // err_count has not yet absorbed this sample
                        pass    <= (err_count == '0) && !mismatch;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        dut_x   <= idx_q + 1'b1;
                        cnt_q   <= CNT_RELOAD;
                        state_q <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TT_CHECK_CAPTURE_EN
    // Per-vector record of what the block actually produced; survives start
    // so the last sweep can be inspected after a relaunch decision.
    logic [N_OUT-1:0] cap_q [NVEC];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NVEC; i++) cap_q[i] <= '0;
        end else if (state_q == SAMPLE) begin
            cap_q[idx_q] <= dut_y;
        end
    end

    assign cap_data = cap_q[cap_addr];
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker. A table-driven fake block (tt[])
// answers dut_x; each launched sweep pushes the result predicted from the
// reference equations into a queue that a negedge monitor drains on done.
module tb_truth_table_checker;

    localparam int S0 = 1;
    localparam int S1 = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] x0, x1, fidx0, fidx1;
    logic [1:0] y0, y1;
    logic       busy0, done0, pass0, fval0;
    logic       busy1, done1, pass1, fval1;
    logic [3:0] err0, err1;
`ifdef TT_CHECK_CAPTURE_EN
    logic [2:0] cap_addr0 = 3'd0;
    logic [2:0] cap_addr1 = 3'd0;
    logic [1:0] cap_data0, cap_data1;
`endif

    logic [1:0] tt [8];
    assign y0 = tt[x0];
    assign y1 = tt[x1];

    truth_table_checker #(.SETTLE_CYCLES(S0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .dut_y(y0),
`ifdef TT_CHECK_CAPTURE_EN
        .cap_addr(cap_addr0), .cap_data(cap_data0),
`endif
        .dut_x(x0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fval0), .fail_idx(fidx0));

    truth_table_checker #(.SETTLE_CYCLES(S1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .dut_y(y1),
`ifdef TT_CHECK_CAPTURE_EN
        .cap_addr(cap_addr1), .cap_data(cap_data1),
`endif
        .dut_x(x1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fval1), .fail_idx(fidx1));

    typedef struct {
        int err;
        int fidx;
        int fval;
        int pass;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int ntest = 0;
    int nfail = 0;
    int cyc = 0;
    int t0a = 0;
    int t0b = 0;

    // Reference block: y0 = x2&(x0|x1), y1 = ~(x0|x1)
    function automatic logic [1:0] good(int x);
        logic [2:0] v;
        v = x[2:0];
        return {~(v[0] | v[1]), v[2] & (v[0] | v[1])};
    endfunction

    function automatic exp_t model(int s);
        exp_t e;
        e.err = 0; e.fidx = 0; e.fval = 0;
        for (int i = 0; i < 8; i++) begin
            if (tt[i] != good(i)) begin
                if (e.fval == 0) begin e.fidx = i; e.fval = 1; end
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        e.cyc  = 8 * (s + 2);
        return e;
    endfunction

    task automatic chk(string n, int a, int e);
        ntest++;
        if (a != e) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    function automatic void set_good();
        for (int i = 0; i < 8; i++) tt[i] = good(i);
    endfunction

    // Start-acceptance time stamps (busy read before the DUT updates it)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && start0 && !busy0) t0a <= cyc + 1;
        if (!rst && start1 && !busy1) t0b <= cyc + 1;
    end

    logic dd0 = 1'b0;
    logic dd1 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy0) chk("x_walk0", int'(x0), (cyc - t0a) / (S0 + 2));
            else       chk("x_idle0", int'(x0), 0);
            if (done0 && !dd0) begin
                if (q0.size() == 0) chk("spurious_done0", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("latency0", cyc - t0a, e.cyc);
                    chk("err_count0", int'(err0), e.err);
                    chk("fail_valid0", int'(fval0), e.fval);
                    chk("fail_idx0", int'(fidx0), e.fidx);
                    chk("pass0", int'(pass0), e.pass);
                end
            end
        end
        dd0 = done0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy1) chk("x_walk1", int'(x1), (cyc - t0b) / (S1 + 2));
            else       chk("x_idle1", int'(x1), 0);
            if (done1 && !dd1) begin
                if (q1.size() == 0) chk("spurious_done1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("latency1", cyc - t0b, e.cyc);
                    chk("err_count1", int'(err1), e.err);
                    chk("fail_valid1", int'(fval1), e.fval);
                    chk("fail_idx1", int'(fidx1), e.fidx);
                    chk("pass1", int'(pass1), e.pass);
                end
            end
        end
        dd1 = done1;
    end

    task automatic go0();
        @(negedge clk);
        start0 = 1'b1;
        q0.push_back(model(S0));
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait0();
        int n = 0;
        while (!done0 && n < 200) begin @(negedge clk); n++; end
        if (!done0) chk("timeout0", 0, 1);
    endtask

    task automatic wait_x0(int v);
        int n = 0;
        while (int'(x0) != v && n < 200) begin @(negedge clk); n++; end
        if (int'(x0) != v) chk("timeout_x0", int'(x0), v);
    endtask

    task automatic zeros0(string n);
        chk({n, "_busy"}, int'(busy0), 0);
        chk({n, "_done"}, int'(done0), 0);
        chk({n, "_pass"}, int'(pass0), 0);
        chk({n, "_err"}, int'(err0), 0);
        chk({n, "_fval"}, int'(fval0), 0);
        chk({n, "_fidx"}, int'(fidx0), 0);
        chk({n, "_x"}, int'(x0), 0);
    endtask

    initial begin
        set_good();
        repeat (3) @(negedge clk);
        zeros0("reset");
        chk("reset_busy1", int'(busy1), 0);
        chk("reset_done1", int'(done1), 0);
        rst = 1'b0;

        // correct block
        go0(); wait0();

        // y0 stuck at 1
        for (int i = 0; i < 8; i++) tt[i] = good(i) | 2'b01;
        go0(); wait0();

        // bit 1 inverted only for vector 6
        set_good();
        tt[6] = good(6) ^ 2'b10;
        go0(); wait0();

        // reset while vector 4 is driven aborts the sweep
        set_good();
        go0();
        wait_x0(4);
        rst = 1'b1;
        @(negedge clk);
        zeros0("abort");
        q0.delete();
        rst = 1'b0;
        go0(); wait0();

        // start while busy is ignored
        go0();
        wait_x0(2);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait0();

        // start held through DONE relaunches after one done cycle
        for (int i = 0; i < 8; i++) tt[i] = good(i) | 2'b01;
        @(negedge clk);
        start0 = 1'b1;
        q0.push_back(model(S0));
        q0.push_back(model(S0));
        @(negedge clk);
        wait0();
        @(negedge clk);
        chk("relaunch_done", int'(done0), 0);
        chk("relaunch_busy", int'(busy0), 1);
        chk("relaunch_err", int'(err0), 0);
        start0 = 1'b0;
        wait0();

        // random faulty blocks
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++)
                tt[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : good(i);
            go0(); wait0();
        end

        // zero settle cycles, random block
        for (int i = 0; i < 8; i++)
            tt[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : good(i);
        tt[5] = 2'($urandom_range(0, 3));
        @(negedge clk);
        start1 = 1'b1;
        q1.push_back(model(S1));
        @(negedge clk);
        start1 = 1'b0;
        begin
            int n = 0;
            while (!done1 && n < 200) begin @(negedge clk); n++; end
            if (!done1) chk("timeout1", 0, 1);
        end
`ifdef TT_CHECK_CAPTURE_EN
        cap_addr1 = 3'd5;
        #1;
        chk("capture5", int'(cap_data1), int'(tt[5]));
        for (int a = 0; a < 8; a++) begin
            cap_addr1 = 3'(a);
            #1;
            chk("capture_all", int'(cap_data1), int'(tt[a]));
        end
`endif
        repeat (3) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
